// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// instruction size and the default boot address.
package fetch_pkg;

  typedef enum logic [2:0] {
    FS_BOOT     = 3'd0,
    FS_FETCH    = 3'd1,
    FS_WAIT_RSP = 3'd2,
    FS_HOLD     = 3'd3,
    FS_HALTED   = 3'd4
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr % INSTR_BYTES) == 32'd0;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the external PC, issues one fetch at a
// time to instruction memory and hands each word with its PC to decode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | first cycle after reset release, load RESET_VECTOR
// FETCH    | request word at pc_value
// WAIT_RSP | request accepted, waiting for (or squashing) the response
// HOLD     | word presented to decode until accepted or flushed
// HALTED   | fetching stopped until reset
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_value,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        pc_increment,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        misalign_fault
);

  localparam logic [2:0] ST_BOOT     = FS_BOOT;
  localparam logic [2:0] ST_FETCH    = FS_FETCH;
  localparam logic [2:0] ST_WAIT_RSP = FS_WAIT_RSP;
  localparam logic [2:0] ST_HOLD     = FS_HOLD;
  localparam logic [2:0] ST_HALTED   = FS_HALTED;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       booted;
  logic       squash;
  logic       squash_next;
  logic       capture;
  logic       inst_clear;
  logic       redir_ok;
  logic       redir_bad;
  logic       req_fire;

  assign redir_ok  = redirect_valid && is_word_aligned(redirect_target);
  assign redir_bad = redirect_valid && !is_word_aligned(redirect_target);

  always_comb begin
    state_next     = state;
    squash_next    = squash;
    capture        = 1'b0;
    inst_clear     = 1'b0;
    pc_load        = 1'b0;
    pc_target      = '0;
    pc_increment   = 1'b0;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    misalign_fault = 1'b0;
    req_fire       = 1'b0;

    case (state)
      ST_BOOT: begin
        // booted keeps the load strobe quiet while rst is still asserted
        if (booted) begin
          pc_load    = 1'b1;
          pc_target  = RESET_VECTOR;
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_addr      = pc_value;
        imem_req_valid = !redirect_valid && !halt;
        req_fire       = imem_req_valid && imem_req_ready;
        if (redir_bad) begin
          misalign_fault = 1'b1;
          state_next     = ST_HALTED;
        end else begin
          if (redir_ok) begin
            pc_load   = 1'b1;
            pc_target = redirect_target;
          end
          if (halt) begin
            state_next = ST_HALTED;
          end else if (req_fire) begin
            state_next = ST_WAIT_RSP;
          end
        end
      end

      ST_WAIT_RSP: begin
        if (redir_bad) begin
          misalign_fault = 1'b1;
          squash_next    = 1'b0;
          state_next     = ST_HALTED;
        end else begin
          if (redir_ok) begin
            pc_load   = 1'b1;
            pc_target = redirect_target;
          end
          if (imem_rsp_valid) begin
            // a redirect landing with the response kills it just like a squash
            if (squash || redir_ok) begin
              squash_next = 1'b0;
              state_next  = ST_FETCH;
            end else begin
              capture      = 1'b1;
              pc_increment = 1'b1;
              state_next   = ST_HOLD;
            end
          end else if (redir_ok) begin
            squash_next = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (redir_bad) begin
          misalign_fault = 1'b1;
          inst_clear     = 1'b1;
          state_next     = ST_HALTED;
        end else if (redir_ok) begin
          pc_load    = 1'b1;
          pc_target  = redirect_target;
          inst_clear = 1'b1;
          state_next = ST_FETCH;
        end else if (inst_ready) begin
          inst_clear = 1'b1;
          state_next = halt ? ST_HALTED : ST_FETCH;
        end
      end

      ST_HALTED: begin
        state_next = ST_HALTED;
      end

      default: begin
        state_next = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_BOOT;
      booted     <= 1'b0;
      squash     <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else begin
      booted <= 1'b1;
      state  <= state_next;
      squash <= squash_next;
      if (capture) begin
        inst_valid <= 1'b1;
        inst_data  <= imem_rdata;
        inst_pc    <= pc_value;
      end else if (inst_clear) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a behavioural PC and a
// variable-latency instruction memory; expected fetches are scoreboarded.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_value;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        pc_increment;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt = 1'b0;
  logic        misalign_fault;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [31:0] req_q[$];
  logic [63:0] inst_q[$];
  int          req_cyc_q[$];
  int          inst_cyc_q[$];
  int          req_hs  = 0;
  int          inst_hs = 0;
  logic [31:0] mon_addr;
  logic [63:0] mon_inst;

  int          mem_lat = 1;
  logic        acc;
  logic [31:0] acc_addr;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .pc_value(pc_value),
    .pc_load(pc_load), .pc_target(pc_target), .pc_increment(pc_increment),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Program_Counter stand-in
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_value <= '0;
    else if (pc_load) pc_value <= pc_target;
    else if (pc_increment) pc_value <= pc_value + 32'd4;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0000_0013 : {a[15:0], 16'h0093};
  endfunction

  // Memory: handshake sampled mid-cycle, response driven just after the edge.
  initial begin
    forever begin
      @(negedge clk);
      acc      = rst && imem_req_valid && imem_req_ready;
      acc_addr = imem_addr;
      if (!rst) pend = 1'b0;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = mem_word(pend_addr);
            pend           = 1'b0;
          end
        end
        if (acc) begin
          pend_addr = acc_addr;
          pend_cnt  = mem_lat - 1;
          if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = mem_word(pend_addr);
          end else begin
            pend = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (pc_load && pc_increment) begin
        errors++;
        $display("FAIL load_inc_overlap cycle %0d got both strobes high, required at most one", cyc_n);
      end
      if (imem_req_valid && imem_req_ready) begin
        req_hs++;
        req_cyc_q.push_back(cyc_n);
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_addr got unexpected request %h, required none", imem_addr);
        end else begin
          mon_addr = req_q.pop_front();
          if (imem_addr !== mon_addr) begin
            errors++;
            $display("FAIL req_addr got %h required %h", imem_addr, mon_addr);
          end
        end
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        inst_hs++;
        inst_cyc_q.push_back(cyc_n);
        checks++;
        if (inst_q.size() == 0) begin
          errors++;
          $display("FAIL inst_out got unexpected pc %h data %h, required none", inst_pc, inst_data);
        end else begin
          mon_inst = inst_q.pop_front();
          if ({inst_pc, inst_data} !== mon_inst) begin
            errors++;
            $display("FAIL inst_out got pc %h data %h required pc %h data %h",
                     inst_pc, inst_data, mon_inst[63:32], mon_inst[31:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic at_posedge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int target);
    for (int i = 0; i < 60 && req_hs < target; i++) tick();
    checks++;
    if (req_hs < target) begin
      errors++;
      $display("FAIL req_timeout got %0d requests required %0d", req_hs, target);
    end
  endtask

  task automatic wait_inst(input int target);
    for (int i = 0; i < 60 && inst_hs < target; i++) tick();
    checks++;
    if (inst_hs < target) begin
      errors++;
      $display("FAIL inst_timeout got %0d instructions required %0d", inst_hs, target);
    end
  endtask

  task automatic push_inst(input logic [31:0] a);
    inst_q.push_back({a, mem_word(a)});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pc_load, pc_increment, imem_req_valid, inst_valid, misalign_fault} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b required 00000",
               {pc_load, pc_increment, imem_req_valid, inst_valid, misalign_fault});
    end
    checks++;
    if ({inst_data, inst_pc, pc_target, imem_addr} !== 128'd0) begin
      errors++;
      $display("FAIL reset_buses got data %h pc %h target %h addr %h required zero",
               inst_data, inst_pc, pc_target, imem_addr);
    end
    at_posedge();
    rst = 1'b1;
    tick();
    checks++;
    if (pc_load !== 1'b0) begin
      errors++;
      $display("FAIL pre_e0_load got %b required 0", pc_load);
    end
    tick();
    checks++;
    if (pc_load !== 1'b1 || pc_target !== RV || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_load got load %b target %h req %b required 1 %h 0",
               pc_load, pc_target, imem_req_valid, RV);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RV || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL first_req got valid %b addr %h load %b required 1 %h 0",
               imem_req_valid, imem_addr, pc_load, RV);
    end
  endtask

  task automatic test_zero_wait();
    int br;
    int bi;
    br = req_hs;
    bi = inst_hs;
    for (int k = 0; k < 3; k++) begin
      req_q.push_back(RV + 32'(4 * k));
      push_inst(RV + 32'(4 * k));
    end
    at_posedge();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    wait_inst(bi + 3);
    at_posedge();
    imem_req_ready = 1'b0;
    checks++;
    if (req_cyc_q.size() < br + 3 || inst_cyc_q.size() < bi + 1) begin
      errors++;
      $display("FAIL cadence got %0d requests required %0d", req_cyc_q.size(), br + 3);
    end else begin
      if (req_cyc_q[br + 1] - req_cyc_q[br] != 3 || req_cyc_q[br + 2] - req_cyc_q[br + 1] != 3) begin
        errors++;
        $display("FAIL cadence got gaps %0d %0d required 3 3",
                 req_cyc_q[br + 1] - req_cyc_q[br], req_cyc_q[br + 2] - req_cyc_q[br + 1]);
      end
      checks++;
      if (inst_cyc_q[bi] - req_cyc_q[br] != 2) begin
        errors++;
        $display("FAIL inst_latency got %0d required 2", inst_cyc_q[bi] - req_cyc_q[br]);
      end
    end
  endtask

  task automatic test_redirect_wait();
    int br;
    int bi;
    br = req_hs;
    bi = inst_hs;
    req_q.push_back(32'h0000_010C);
    at_posedge();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    wait_req(br + 1);
    at_posedge();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0200;
    tick();
    checks++;
    if (pc_load !== 1'b1 || pc_target !== 32'h0000_0200 || pc_increment !== 1'b0) begin
      errors++;
      $display("FAIL wait_redirect got load %b target %h inc %b required 1 00000200 0",
               pc_load, pc_target, pc_increment);
    end
    req_q.push_back(32'h0000_0200);
    push_inst(32'h0000_0200);
    at_posedge();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (pc_increment !== 1'b0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL squash_drop got inc %b inst_valid %b required 0 0", pc_increment, inst_valid);
      end
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL squash_refetch got inst_valid %b req %b addr %h required 0 1 00000200",
               inst_valid, imem_req_valid, imem_addr);
    end
    wait_inst(bi + 1);
    at_posedge();
    imem_req_ready = 1'b0;
  endtask

  task automatic test_redirect_coincident();
    int br;
    int bi;
    br = req_hs;
    bi = inst_hs;
    req_q.push_back(32'h0000_0204);
    at_posedge();
    mem_lat = 2;
    imem_req_ready = 1'b1;
    wait_req(br + 1);
    tick();
    at_posedge();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0300;
    tick();
    checks++;
    if (pc_load !== 1'b1 || pc_target !== 32'h0000_0300 || pc_increment !== 1'b0) begin
      errors++;
      $display("FAIL coincident_load got load %b target %h inc %b required 1 00000300 0",
               pc_load, pc_target, pc_increment);
    end
    req_q.push_back(32'h0000_0300);
    push_inst(32'h0000_0300);
    at_posedge();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL coincident_drop got inst_valid %b req %b required 0 1", inst_valid, imem_req_valid);
    end
    wait_inst(bi + 1);
    at_posedge();
    imem_req_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    int br;
    int bi;
    br = req_hs;
    bi = inst_hs;
    req_q.push_back(32'h0000_0304);
    at_posedge();
    inst_ready = 1'b0;
    mem_lat = 1;
    imem_req_ready = 1'b1;
    wait_req(br + 1);
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0304 || inst_data !== mem_word(32'h0000_0304)
          || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable got valid %b pc %h data %h req %b required 1 00000304 %h 0",
                 inst_valid, inst_pc, inst_data, imem_req_valid, mem_word(32'h0000_0304));
      end
    end
    at_posedge();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0400;
    tick();
    checks++;
    if (pc_load !== 1'b1 || pc_target !== 32'h0000_0400) begin
      errors++;
      $display("FAIL hold_redirect got load %b target %h required 1 00000400", pc_load, pc_target);
    end
    req_q.push_back(32'h0000_0400);
    push_inst(32'h0000_0400);
    at_posedge();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_flush got inst_valid %b required 0", inst_valid);
    end
    at_posedge();
    inst_ready = 1'b1;
    wait_inst(bi + 1);
    at_posedge();
    imem_req_ready = 1'b0;
  endtask

  task automatic test_misalign();
    int br;
    br = req_hs;
    req_q.push_back(32'h0000_0404);
    at_posedge();
    mem_lat = 2;
    imem_req_ready = 1'b1;
    wait_req(br + 1);
    at_posedge();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0202;
    tick();
    checks++;
    if (misalign_fault !== 1'b1 || pc_load !== 1'b0 || pc_increment !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse got fault %b load %b inc %b required 1 0 0",
               misalign_fault, pc_load, pc_increment);
    end
    at_posedge();
    redirect_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({misalign_fault, imem_req_valid, pc_load, pc_increment, inst_valid} !== 5'b0) begin
        errors++;
        $display("FAIL halted_quiet got %b required 00000",
                 {misalign_fault, imem_req_valid, pc_load, pc_increment, inst_valid});
      end
    end
    checks++;
    if (pc_value !== 32'h0000_0404) begin
      errors++;
      $display("FAIL halted_pc got %h required 00000404", pc_value);
    end
  endtask

  task automatic test_reset_mid();
    int br;
    at_posedge();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    at_posedge();
    rst = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RV) begin
      errors++;
      $display("FAIL reboot_req got valid %b addr %h required 1 %h", imem_req_valid, imem_addr, RV);
    end
    br = req_hs;
    req_q.push_back(RV);
    at_posedge();
    mem_lat = 3;
    imem_req_ready = 1'b1;
    wait_req(br + 1);
    tick();
    at_posedge();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if ({pc_load, pc_increment, imem_req_valid, inst_valid, misalign_fault} !== 5'b0
        || inst_data !== 32'd0 || inst_pc !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got strobes %b data %h pc %h required 00000 0 0",
               {pc_load, pc_increment, imem_req_valid, inst_valid, misalign_fault}, inst_data, inst_pc);
    end
    tick();
    at_posedge();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (pc_load !== 1'b1 || pc_target !== RV || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_boot got load %b target %h inst_valid %b required 1 %h 0",
               pc_load, pc_target, inst_valid, RV);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_redirect_wait();
    test_redirect_coincident();
    test_hold_stall();
    test_misalign();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (req_q.size() != 0 || inst_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d requests %0d instructions outstanding required 0 0",
               req_q.size(), inst_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
